multi_wdt_ctrl: RTL
===================

MULTI_WDT_CTRL -- requirements
Module: multi_wdt_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent watchdog channels (1..8).
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0801: channel n command register at BASE_ADDR+n.
REQ-003 SHALL have parameter TMO_W, default 16: timeout counter width.
REQ-004 SHALL have parameter TMO_LOAD, default 16'd32768: reload value, in CLK32768 cycles (1 s).
REQ-005 SHALL have port CLK32768 input 1: watchdog time-base clock.
REQ-006 SHALL have port MainResetN input 1: reset for all domains, asynchronous, active-low.
REQ-007 SHALL have port Mclkx input 1: host bus clock.
REQ-008 SHALL have port DevCs_En input 1: host device write strobe, Mclkx domain, held for one or more Mclkx cycles per write.
REQ-009 SHALL have port DevAddr input 16: host write address.
REQ-010 SHALL have port WrDev_Data input 8: host write data.
REQ-011 SHALL have port WdtRunning output NUM_CH: channel in RUN state.
REQ-012 SHALL have port WdtExpired output NUM_CH: channel in EXPIRED state.
REQ-013 SHALL have port WdtRstReqN output 1: active-low one-cycle pulse when any channel enters EXPIRED.
REQ-014 SHALL have port BadCmdCnt output 8: saturating count of unrecognised command writes.

Function
REQ-015 Host decode, Mclkx domain: one command SHALL be accepted per continuous assertion of DevCs_En with DevAddr in BASE_ADDR..BASE_ADDR+NUM_CH-1; further cycles of the same assertion SHALL be ignored until DevCs_En deasserts or the address leaves range.
REQ-016 Command codes SHALL be: 8'h29 ARM, 8'h55 KICK, 8'hFF DISARM, 8'hAA CLEAR; any other value is BAD.
REQ-017 Each accepted (channel, command) SHALL flip its own toggle bit. BAD SHALL flip a single shared toggle.
REQ-018 Every toggle SHALL cross to CLK32768 through a 2-flop synchroniser plus edge-detect register, giving a one-cycle pulse 2-3 CLK32768 cycles after the Mclkx edge.
REQ-019 Host SHALL space repeat writes of the same (channel, command) at least 4 CLK32768 cycles apart; closer writes are not guaranteed to be counted.
REQ-020 Per-channel FSM states SHALL be IDLE, RUN, EXPIRED.
- IDLE: ARM -> RUN, counter := TMO_LOAD.
- RUN: KICK or ARM -> counter := TMO_LOAD; DISARM -> IDLE; otherwise decrement by 1.
- RUN with counter==1 and no reload -> EXPIRED, counter := 0.
- EXPIRED: CLEAR -> IDLE; all other commands ignored.
- KICK, DISARM and CLEAR in IDLE SHALL be ignored.
REQ-021 Same-cycle pulses on one channel SHALL be resolved DISARM > CLEAR > ARM > KICK. A reload SHALL win over expiry in the same cycle.
REQ-022 Counter SHALL never wrap below 0.
REQ-023 WdtRunning[n] and WdtExpired[n] SHALL be registered decodes of the state (RUN and EXPIRED respectively).
REQ-024 WdtRstReqN SHALL be low for exactly one CLK32768 cycle, the cycle after any channel enters EXPIRED. Simultaneous expiries SHALL give one pulse.
REQ-025 BadCmdCnt SHALL increment by 1 per BAD pulse and saturate at 8'hFF.

Reset
REQ-026 MainResetN low SHALL asynchronously clear all Mclkx and CLK32768 flops.
- Resulting values: all toggles 0, FSMs IDLE, counters 0, WdtRunning 0, WdtExpired 0, WdtRstReqN 1, BadCmdCnt 0.
REQ-027 Reset mid-countdown SHALL discard state. No spurious pulse SHALL be generated on reset release, because both toggle domains restart at 0.

Structure
REQ-028 Package wdt_pkg SHALL hold the command code constants, the FSM state typedef and encoding, and the NUM_CH upper bound.
REQ-029 Sub-module wdt_toggle_sync SHALL implement one toggle -> 2-flop sync -> edge pulse. It SHALL be instantiated NUM_CH*4+1 times.
REQ-030 No combinational path SHALL cross between Mclkx and CLK32768.

Verification (bench: NUM_CH=2, TMO_LOAD=8, Mclkx 33 MHz)
REQ-031 Write 8'h29 to 0x0801 -> WdtRunning=2'b01 within 3 CLK32768 cycles; with no kick, WdtExpired[0]=1 eight cycles after arm, and WdtRstReqN low for 1 cycle.
REQ-032 Arm ch1 (0x0802), then write 8'h55 every 5 cycles for 40 cycles -> WdtExpired[1] stays 0; stop kicking -> expires 8 cycles after the last kick.
REQ-033 DevCs_En held 10 Mclkx cycles with 8'h42 at 0x0801 -> BadCmdCnt=1. Then 300 BAD writes -> BadCmdCnt=8'hFF.
REQ-034 Expired ch0, write 8'h55 then 8'hFF -> remains EXPIRED; write 8'hAA -> WdtExpired[0]=0, IDLE.
REQ-035 Write KICK on the cycle the counter reaches 1 -> reload, no expiry. Write to 0x0803 (out of range) -> no effect.
REQ-036 Assert MainResetN low mid-countdown, then release -> all outputs at reset values, no WdtRstReqN pulse, no state change for 10 cycles.

Source files
------------

// File: rtl/wdt_pkg.sv
// -----------------------------------------------------------------------------
// wdt_pkg
// Shared definitions for the multi-channel watchdog controller:
//   - host command byte codes (ARM / KICK / DISARM / CLEAR)
//   - per-channel command pulse bundle, one bit per command
//   - watchdog channel FSM state encoding
//   - upper bound on the number of channels
//   - helper that turns a host data byte into a one-hot command vector
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package wdt_pkg;

   localparam int NUM_CH_MAX = 8;
   localparam int NUM_CMD    = 4;

   localparam logic [7:0] CMD_ARM    = 8'h29;
   localparam logic [7:0] CMD_KICK   = 8'h55;
   localparam logic [7:0] CMD_DISARM = 8'hFF;
   localparam logic [7:0] CMD_CLEAR  = 8'hAA;

   // Bit order matches the one-hot vector returned by cmd_onehot() and the
   // order of the toggle synchronisers within a channel (arm is bit 0).
   typedef struct packed {
      logic clear;
      logic disarm;
      logic kick;
      logic arm;
   } cmd_pulse_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_EXPIRED = 2'b10
   } wdt_state_e;

   // All-zero result means the byte is not a recognised command.
   function automatic logic [NUM_CMD-1:0] cmd_onehot(input logic [7:0] data);
      logic [NUM_CMD-1:0] oh;
      oh = '0;
      case (data)
         CMD_ARM:    oh[0] = 1'b1;
         CMD_KICK:   oh[1] = 1'b1;
         CMD_DISARM: oh[2] = 1'b1;
         CMD_CLEAR:  oh[3] = 1'b1;
         default:    oh    = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/wdt_toggle_sync.sv
// -----------------------------------------------------------------------------
// wdt_toggle_sync
// Carries single events from the host clock domain into the watchdog time-base
// domain. Each flip request inverts a toggle flop in the source domain; the
// toggle level is resynchronised through two flops and an edge register in the
// destination domain, and any level change becomes a one-cycle pulse.
//
// Ports
//   src_clk_i : source (host bus) clock
//   dst_clk_i : destination (watchdog time-base) clock
//   rst_ni    : asynchronous active-low reset for both domains
//   flip_i    : one source-cycle request to send an event
//   pulse_o   : one destination-cycle event pulse
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module wdt_toggle_sync (
   input  logic src_clk_i,
   input  logic dst_clk_i,
   input  logic rst_ni,
   input  logic flip_i,
   output logic pulse_o
);

   logic tog_q, tog_d;
   logic sync1_q, sync2_q, edge_q;

   assign tog_d = tog_q ^ flip_i;

   always_ff @(posedge src_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tog_q <= 1'b0;
      end else begin
         tog_q <= tog_d;
      end
   end

   // Only a flop output (tog_q) crosses into the destination domain.
   always_ff @(posedge dst_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         sync1_q <= tog_q;
         sync2_q <= sync1_q;
         edge_q  <= sync2_q;
      end
   end

   assign pulse_o = sync2_q ^ edge_q;

endmodule

// File: rtl/multi_wdt_ctrl.sv
// -----------------------------------------------------------------------------
// multi_wdt_ctrl
// NUM_CH independent watchdog channels controlled by host byte writes.
// Host writes are decoded in the Mclkx domain and sent as toggle events to the
// CLK32768 domain, where each channel runs an IDLE/RUN/EXPIRED state machine
// with a reloadable down-counter.
//
// Ports
//   CLK32768    : watchdog time-base clock
//   MainResetN  : asynchronous active-low reset, both clock domains
//   Mclkx       : host bus clock
//   DevCs_En    : host write strobe (Mclkx), may be held several cycles
//   DevAddr     : host write address, channel n at BASE_ADDR+n
//   WrDev_Data  : host write data (command byte)
//   WdtRunning  : per channel, state is RUN
//   WdtExpired  : per channel, state is EXPIRED
//   WdtRstReqN  : active-low one-cycle pulse when any channel expires
//   BadCmdCnt   : saturating count of unrecognised command writes
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module multi_wdt_ctrl
   import wdt_pkg::*;
#(
   parameter int               NUM_CH    = 2,
   parameter logic [15:0]      BASE_ADDR = 16'h0801,
   parameter int               TMO_W     = 16,
   parameter logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(32768)
) (
   input  logic              CLK32768,
   input  logic              MainResetN,
   input  logic              Mclkx,
   input  logic              DevCs_En,
   input  logic [15:0]       DevAddr,
   input  logic [7:0]        WrDev_Data,
   output logic [NUM_CH-1:0] WdtRunning,
   output logic [NUM_CH-1:0] WdtExpired,
   output logic              WdtRstReqN,
   output logic [7:0]        BadCmdCnt
);

   // NUM_CH is expected to lie in 1..NUM_CH_MAX.
   localparam int NUM_TOG = NUM_CH * NUM_CMD;

   // ---------------------------------------------------------------------------
   // Host decode (Mclkx domain)
   // ---------------------------------------------------------------------------
   logic [NUM_CH-1:0]  addr_hit;
   logic [NUM_CMD-1:0] cmd_oh;
   logic               in_range;
   logic               accept;
   logic               held_q, held_d;
   logic [NUM_TOG-1:0] flip_ch;
   logic               flip_bad;

   always_comb begin
      cmd_oh   = cmd_onehot(WrDev_Data);
      addr_hit = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         addr_hit[ch] = (DevAddr == (BASE_ADDR + 16'(ch)));
      end
      in_range = DevCs_En & (|addr_hit);
      // held_q remembers that the current strobe already delivered its command,
      // so a long strobe produces exactly one event.
      held_d   = in_range;
      accept   = in_range & ~held_q;
      flip_ch  = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         flip_ch[ch*NUM_CMD +: NUM_CMD] = {NUM_CMD{accept & addr_hit[ch]}} & cmd_oh;
      end
      flip_bad = accept & ~(|cmd_oh);
   end

   always_ff @(posedge Mclkx or negedge MainResetN) begin
      if (!MainResetN) begin
         held_q <= 1'b0;
      end else begin
         held_q <= held_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Event transfer to CLK32768: one toggle synchroniser per (channel, command)
   // plus one shared for unrecognised commands.
   // ---------------------------------------------------------------------------
   logic [NUM_TOG-1:0] pulse_ch;
   logic               pulse_bad;

   for (genvar i = 0; i < NUM_TOG; i++) begin : g_sync
      wdt_toggle_sync u_sync (
         .src_clk_i (Mclkx),
         .dst_clk_i (CLK32768),
         .rst_ni    (MainResetN),
         .flip_i    (flip_ch[i]),
         .pulse_o   (pulse_ch[i])
      );
   end

   wdt_toggle_sync u_sync_bad (
      .src_clk_i (Mclkx),
      .dst_clk_i (CLK32768),
      .rst_ni    (MainResetN),
      .flip_i    (flip_bad),
      .pulse_o   (pulse_bad)
   );

   // ---------------------------------------------------------------------------
   // Watchdog channels (CLK32768 domain)
   // ---------------------------------------------------------------------------
   logic [NUM_CH-1:0] expire_vec;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      cmd_pulse_t       p;
      wdt_state_e       state_q;
      logic [TMO_W-1:0] cnt_q;
      logic             run_q;
      logic             exp_q;
      logic             reload;
      logic             expire_now;

      assign p      = cmd_pulse_t'(pulse_ch[ch*NUM_CMD +: NUM_CMD]);
      // CLEAR has no effect in RUN, so only DISARM can pre-empt a reload.
      assign reload = p.arm | p.kick;
      // A reload in the final count cycle wins over expiry.
      assign expire_now = (state_q == ST_RUN) & ~p.disarm & ~reload &
                          (cnt_q == TMO_W'(1));

      always_ff @(posedge CLK32768 or negedge MainResetN) begin
         if (!MainResetN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            exp_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  // DISARM and CLEAR outrank ARM even though they do nothing here.
                  if (p.arm & ~p.disarm & ~p.clear) begin
                     state_q <= ST_RUN;
                     cnt_q   <= TMO_LOAD;
                     run_q   <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (p.disarm) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                     run_q   <= 1'b0;
                  end else if (reload) begin
                     cnt_q <= TMO_LOAD;
                  end else if (expire_now) begin
                     state_q <= ST_EXPIRED;
                     cnt_q   <= '0;
                     run_q   <= 1'b0;
                     exp_q   <= 1'b1;
                  end else if (cnt_q != '0) begin
                     cnt_q <= cnt_q - TMO_W'(1);
                  end
               end
               ST_EXPIRED: begin
                  if (p.clear) begin
                     state_q <= ST_IDLE;
                     exp_q   <= 1'b0;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  run_q   <= 1'b0;
                  exp_q   <= 1'b0;
               end
            endcase
         end
      end

      assign WdtRunning[ch] = run_q;
      assign WdtExpired[ch] = exp_q;
      assign expire_vec[ch] = expire_now;
   end

   // ---------------------------------------------------------------------------
   // Reset request and bad-command counter (CLK32768 domain)
   // ---------------------------------------------------------------------------
   logic       rst_req_n_q;
   logic [7:0] bad_cnt_q;

   always_ff @(posedge CLK32768 or negedge MainResetN) begin
      if (!MainResetN) begin
         rst_req_n_q <= 1'b1;
         bad_cnt_q   <= '0;
      end else begin
         // Goes low together with the EXPIRED state; concurrent expiries merge.
         rst_req_n_q <= ~(|expire_vec);
         if (pulse_bad && (bad_cnt_q != 8'hFF)) begin
            bad_cnt_q <= bad_cnt_q + 8'd1;
         end
      end
   end

   assign WdtRstReqN = rst_req_n_q;
   assign BadCmdCnt  = bad_cnt_q;

endmodule
